eth_csr_init_seq: RTL and testbench



---
 rtl/eth_csr_init_seq.sv | 233 +++++++++++++++++++++++
 tb/tb_eth_csr_init_seq.sv | 455 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/eth_csr_init_seq.sv
// -----------------------------------------------------------------------------
// eth_csr_init_seq
//
// Boot-time configuration sequencer. Masters the AXI4-Lite CSR port of the
// Ethernet wrapper and replays a fixed table of register writes, one at a time,
// waiting for each write response before issuing the next. The outcome is
// reported as level outputs so SoC boot logic can release the CPU or flag an
// error.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   start_i           pulse; (re)launch from IDLE/DONE/ERR, ignored while busy
//   busy_o            sequence in progress
//   done_o            all writes returned OKAY (level)
//   error_o           a write returned non-OKAY or timed out (level)
//   err_idx_o         table index of the failing write
//   m_aw*, m_w*, m_b* AXI4-Lite write channels (master side)
//   m_ar*, m_r*       read channels, tied off (never used)
// -----------------------------------------------------------------------------
module eth_csr_init_seq #(
    parameter int unsigned          NUM_WR     = 4,
    parameter logic [NUM_WR*32-1:0] INIT_ADDR  = {NUM_WR{32'h0}},
    parameter logic [NUM_WR*32-1:0] INIT_DATA  = {NUM_WR{32'h0}},
    parameter bit                   AUTO_START = 1'b1,
    parameter int unsigned          TIMEOUT    = 1024,
    parameter int unsigned          ID_W       = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start_i,
    output logic            busy_o,
    output logic            done_o,
    output logic            error_o,
    output logic [3:0]      err_idx_o,
    // write address channel
    output logic [ID_W-1:0] m_awid,
    output logic [31:0]     m_awaddr,
    output logic [2:0]      m_awprot,
    output logic            m_awvalid,
    input  logic            m_awready,
    // write data channel
    output logic [31:0]     m_wdata,
    output logic [3:0]      m_wstrb,
    output logic            m_wvalid,
    input  logic            m_wready,
    // write response channel
    input  logic [ID_W-1:0] m_bid,
    input  logic [1:0]      m_bresp,
    input  logic            m_bvalid,
    output logic            m_bready,
    // read channels (tied off)
    output logic [ID_W-1:0] m_arid,
    output logic [31:0]     m_araddr,
    output logic [2:0]      m_arprot,
    output logic            m_arvalid,
    input  logic            m_arready,
    input  logic [ID_W-1:0] m_rid,
    input  logic [31:0]     m_rdata,
    input  logic [1:0]      m_rresp,
    input  logic            m_rvalid,
    output logic            m_rready
);

    localparam int unsigned   TW        = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT - 1);
    localparam logic [3:0]    LAST_IDX  = 4'(NUM_WR - 1);
    localparam logic [1:0]    RESP_OKAY = 2'b00;

    typedef enum logic [2:0] {IDLE, ISSUE, RESP, DONE, ERR} state_t;

    state_t        state, state_d;
    logic [3:0]    idx, idx_d;
    logic [3:0]    err_idx, err_idx_d;
    logic [TW-1:0] tcnt, tcnt_d;
    logic          issued, issued_d;   // valids raised for the current write
    logic          aw_acc, aw_acc_d;   // AW beat of the current write accepted
    logic          w_acc, w_acc_d;     // W beat of the current write accepted
    logic          awvalid, awvalid_d;
    logic          wvalid, wvalid_d;
    logic          bready, bready_d;
    logic          launch_pend;        // high only on the first cycle after reset

    logic aw_hs, w_hs, b_hs, tmo;

    assign aw_hs = awvalid & m_awready;
    assign w_hs  = wvalid & m_wready;
    assign b_hs  = bready & m_bvalid;
    assign tmo   = (tcnt == TMO_LAST);

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values of its peers regardless of evaluation order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            idx         <= '0;
            err_idx     <= '0;
            tcnt        <= '0;
            issued      <= 1'b0;
            aw_acc      <= 1'b0;
            w_acc       <= 1'b0;
            awvalid     <= 1'b0;
            wvalid      <= 1'b0;
            bready      <= 1'b0;
            launch_pend <= AUTO_START;
        end else begin
            state       <= state_d;
            idx         <= idx_d;
            err_idx     <= err_idx_d;
            tcnt        <= tcnt_d;
            issued      <= issued_d;
            aw_acc      <= aw_acc_d;
            w_acc       <= w_acc_d;
            awvalid     <= awvalid_d;
            wvalid      <= wvalid_d;
            bready      <= bready_d;
            launch_pend <= 1'b0;
        end
    end

    always_comb begin
        // NOTE: every signal driven here gets a default first; any path that
        // skipped an assignment would otherwise infer a latch.
        state_d   = state;
        idx_d     = idx;
        err_idx_d = err_idx;
        tcnt_d    = tcnt;
        issued_d  = issued;
        aw_acc_d  = aw_acc;
        w_acc_d   = w_acc;
        awvalid_d = awvalid;
        wvalid_d  = wvalid;
        bready_d  = bready;

        unique case (state)
            IDLE, DONE, ERR: begin
                // launch_pend can only be set while still in IDLE
                if (start_i || launch_pend) begin
                    state_d   = ISSUE;
                    idx_d     = '0;
                    err_idx_d = '0;
                    tcnt_d    = '0;
                    issued_d  = 1'b0;
                    aw_acc_d  = 1'b0;
                    w_acc_d   = 1'b0;
                end
            end

            ISSUE: begin
                if (aw_hs) begin
                    awvalid_d = 1'b0;
                    aw_acc_d  = 1'b1;
                end
                if (w_hs) begin
                    wvalid_d = 1'b0;
                    w_acc_d  = 1'b1;
                end
                if (!issued) begin
                    // First ISSUE cycle is the bus gap; the timeout window
                    // opens only once the valids are up.
                    issued_d  = 1'b1;
                    awvalid_d = 1'b1;
                    wvalid_d  = 1'b1;
                end else if (tmo) begin
                    state_d   = ERR;
                    err_idx_d = idx;
                    awvalid_d = 1'b0;
                    wvalid_d  = 1'b0;
                end else begin
                    tcnt_d = tcnt + 1'b1;
                    if ((aw_acc || aw_hs) && (w_acc || w_hs)) begin
                        state_d  = RESP;
                        bready_d = 1'b1;
                    end
                end
            end

            RESP: begin
                // a response landing on the timeout cycle wins over the abort
                if (b_hs) begin
                    bready_d = 1'b0;
                    if (m_bresp != RESP_OKAY) begin
                        state_d   = ERR;
                        err_idx_d = idx;
                    end else if (idx == LAST_IDX) begin
                        state_d = DONE;
                    end else begin
                        state_d  = ISSUE;
                        idx_d    = idx + 4'd1;
                        tcnt_d   = '0;
                        issued_d = 1'b0;
                        aw_acc_d = 1'b0;
                        w_acc_d  = 1'b0;
                    end
                end else if (tmo) begin
                    state_d   = ERR;
                    err_idx_d = idx;
                    bready_d  = 1'b0;
                end else begin
                    tcnt_d = tcnt + 1'b1;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    // idx is frozen while a write is outstanding, so address and data are
    // stable for as long as their valids are high.
    assign m_awaddr  = INIT_ADDR[idx*32 +: 32];
    assign m_wdata   = INIT_DATA[idx*32 +: 32];
    assign m_awid    = '0;
    assign m_awprot  = 3'b000;
    assign m_awvalid = awvalid;
    assign m_wstrb   = 4'hF;
    assign m_wvalid  = wvalid;
    assign m_bready  = bready;

    assign m_arid    = '0;
    assign m_araddr  = '0;
    assign m_arprot  = 3'b000;
    assign m_arvalid = 1'b0;
    assign m_rready  = 1'b1;

    assign busy_o    = (state == ISSUE) || (state == RESP);
    assign done_o    = (state == DONE);
    assign error_o   = (state == ERR);
    assign err_idx_o = err_idx;

    // Response ID and the whole read path carry nothing this block needs.
    logic unused_inputs;
    assign unused_inputs = ^{m_bid, m_arready, m_rid, m_rdata, m_rresp, m_rvalid};

endmodule

// File: tb/tb_eth_csr_init_seq.sv
// -----------------------------------------------------------------------------
// tb_eth_csr_init_seq
//
// Self-checking bench for eth_csr_init_seq. A behavioural AXI4-Lite slave with
// configurable/randomised per-channel delays logs every accepted beat; each
// test task compares the log and status outputs against a reference model
// derived from the write table and the sequencing rules.
// -----------------------------------------------------------------------------
module tb_eth_csr_init_seq;

    localparam int NW  = 4;
    localparam int TMO = 16;
    localparam logic [NW*32-1:0] TB_ADDR =
        {32'h0000_0108, 32'h0000_0104, 32'h0000_0020, 32'h0000_0010};
    localparam logic [NW*32-1:0] TB_DATA =
        {32'h0000_0003, 32'hFFFF_FF00, 32'hC0A8_0001, 32'h0A0B_0C0D};

    logic        clk, rst, start_i;
    logic        busy_o, done_o, error_o;
    logic [3:0]  err_idx_o;
    logic [7:0]  m_awid, m_bid, m_arid, m_rid;
    logic [31:0] m_awaddr, m_wdata, m_araddr, m_rdata;
    logic [2:0]  m_awprot, m_arprot;
    logic [3:0]  m_wstrb;
    logic [1:0]  m_bresp, m_rresp;
    logic        m_awvalid, m_awready, m_wvalid, m_wready;
    logic        m_bvalid, m_bready, m_arvalid, m_arready, m_rvalid, m_rready;

    eth_csr_init_seq #(
        .NUM_WR(NW), .INIT_ADDR(TB_ADDR), .INIT_DATA(TB_DATA),
        .AUTO_START(1'b1), .TIMEOUT(TMO), .ID_W(8)
    ) dut (
        .clk(clk), .rst(rst), .start_i(start_i),
        .busy_o(busy_o), .done_o(done_o), .error_o(error_o), .err_idx_o(err_idx_o),
        .m_awid(m_awid), .m_awaddr(m_awaddr), .m_awprot(m_awprot),
        .m_awvalid(m_awvalid), .m_awready(m_awready),
        .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
        .m_bid(m_bid), .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
        .m_arid(m_arid), .m_araddr(m_araddr), .m_arprot(m_arprot),
        .m_arvalid(m_arvalid), .m_arready(m_arready),
        .m_rid(m_rid), .m_rdata(m_rdata), .m_rresp(m_rresp),
        .m_rvalid(m_rvalid), .m_rready(m_rready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // ---------------- reference model ----------------
    logic [31:0] ref_addr [NW];
    logic [31:0] ref_data [NW];

    function automatic int exp_writes(input int fail_at);
        return (fail_at >= 0 && fail_at < NW) ? fail_at + 1 : NW;
    endfunction

    function automatic int exp_done_cycle();
        return 3 * NW + 1;
    endfunction

    // ---------------- behavioural slave ----------------
    int aw_min = 0, aw_max = 0, w_min = 0, w_max = 0, b_min = 0, b_max = 0;
    int err_at = -1;
    bit never_b = 1'b0;

    int aw_cnt, w_cnt, b_cnt, txn;
    bit aw_got, w_got, b_pend, b_acc;
    logic prev_awv, prev_awr, prev_wv, prev_wr;
    logic [31:0] prev_awaddr, prev_wdata;

    logic [31:0] aw_log[$];
    logic [31:0] w_log[$];
    logic [3:0]  strb_log[$];
    int b_log = 0;
    int stab_err = 0;

    task automatic slave_reset();
        m_awready = 1'b0; m_wready = 1'b0; m_bvalid = 1'b0; m_bresp = 2'b00;
        aw_got = 1'b0; w_got = 1'b0; b_pend = 1'b0; b_acc = 1'b0; txn = 0;
        prev_awv = 1'b0; prev_awr = 1'b0; prev_wv = 1'b0; prev_wr = 1'b0;
        prev_awaddr = '0; prev_wdata = '0;
        aw_cnt = $urandom_range(aw_max, aw_min);
        w_cnt  = $urandom_range(w_max, w_min);
        b_cnt  = 0;
    endtask

    task automatic clear_log();
        aw_log.delete(); w_log.delete(); strb_log.delete();
        b_log = 0; stab_err = 0;
    endtask

    // Slave decides its inputs at the falling edge; a beat is logged when
    // valid and ready are both high, i.e. it completes at the next rising edge.
    initial begin
        m_bid = '0; m_arready = 1'b0; m_rid = '0; m_rdata = '0;
        m_rresp = '0; m_rvalid = 1'b0;
        slave_reset();
        forever begin
            @(negedge clk);
            if (rst) begin
                slave_reset();
            end else begin
                if (prev_awv && !prev_awr && (!m_awvalid || m_awaddr !== prev_awaddr)) stab_err++;
                if (prev_wv && !prev_wr && (!m_wvalid || m_wdata !== prev_wdata)) stab_err++;
                if (b_acc) begin
                    m_bvalid = 1'b0;
                    b_acc    = 1'b0;
                end
                if (b_pend && !never_b) begin
                    if (b_cnt == 0) begin
                        m_bvalid = 1'b1;
                        m_bresp  = (txn == err_at) ? 2'b10 : 2'b00;
                        if (m_bready) begin
                            b_log++; b_pend = 1'b0; b_acc = 1'b1; txn++;
                        end
                    end else begin
                        b_cnt--;
                    end
                end
                m_awready = 1'b0;
                if (m_awvalid) begin
                    if (aw_cnt == 0) begin
                        m_awready = 1'b1; aw_got = 1'b1; aw_log.push_back(m_awaddr);
                    end else aw_cnt--;
                end
                m_wready = 1'b0;
                if (m_wvalid) begin
                    if (w_cnt == 0) begin
                        m_wready = 1'b1; w_got = 1'b1;
                        w_log.push_back(m_wdata); strb_log.push_back(m_wstrb);
                    end else w_cnt--;
                end
                prev_awv = m_awvalid; prev_awr = m_awready; prev_awaddr = m_awaddr;
                prev_wv  = m_wvalid;  prev_wr  = m_wready;  prev_wdata  = m_wdata;
                if (aw_got && w_got) begin
                    aw_got = 1'b0; w_got = 1'b0; b_pend = 1'b1;
                    b_cnt  = $urandom_range(b_max, b_min);
                    aw_cnt = $urandom_range(aw_max, aw_min);
                    w_cnt  = $urandom_range(w_max, w_min);
                end
            end
        end
    end

    // ---------------- helpers (stimulus / timing only) ----------------
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic pulse_start();
        tick();
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
    endtask

    task automatic set_delays(input int amin, amax, wmin, wmax, bmin, bmax);
        aw_min = amin; aw_max = amax; w_min = wmin; w_max = wmax;
        b_min = bmin; b_max = bmax;
    endtask

    task automatic wait_end(input int budget, output int cyc);
        cyc = -1;
        for (int c = 1; c <= budget; c++) begin
            tick();
            if (done_o || error_o) begin
                cyc = c;
                break;
            end
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        vectors++;
        if ({m_awvalid, m_wvalid, m_bready, busy_o, done_o, error_o} !== 6'b0) begin
            miscompares++;
            $display("FAIL reset_ctrl: got %b, expected 000000",
                     {m_awvalid, m_wvalid, m_bready, busy_o, done_o, error_o});
        end
        vectors++;
        if (err_idx_o !== 4'd0 || m_awaddr !== ref_addr[0]) begin
            miscompares++;
            $display("FAIL reset_idx: got err_idx %0d addr %h, expected 0 %h",
                     err_idx_o, m_awaddr, ref_addr[0]);
        end
        vectors++;
        if ({m_awid, m_awprot, m_wstrb, m_arvalid, m_rready, m_araddr} !==
            {8'h00, 3'b000, 4'hF, 1'b0, 1'b1, 32'h0}) begin
            miscompares++;
            $display("FAIL reset_const: got %h", {m_awid, m_awprot, m_wstrb, m_arvalid, m_rready, m_araddr});
        end
    endtask

    task automatic test_zero_wait();
        int  cyc;
        bit  prev_busy;
        set_delays(0, 0, 0, 0, 0, 0);
        err_at = -1;
        slave_reset();
        clear_log();
        rst = 1'b0;
        cyc = -1;
        prev_busy = 1'b0;
        for (int c = 1; c <= 100; c++) begin
            tick();
            if (done_o || error_o) begin
                cyc = c;
                break;
            end
            prev_busy = busy_o;
        end
        vectors++;
        if (cyc !== exp_done_cycle()) begin
            miscompares++;
            $display("FAIL zw_latency: done at cycle %0d, expected %0d", cyc, exp_done_cycle());
        end
        vectors++;
        if ({prev_busy, busy_o, done_o, error_o} !== 4'b1010) begin
            miscompares++;
            $display("FAIL zw_status: got busy_prev/busy/done/err %b, expected 1010",
                     {prev_busy, busy_o, done_o, error_o});
        end
        vectors++;
        if (aw_log.size() != NW || w_log.size() != NW || b_log != NW) begin
            miscompares++;
            $display("FAIL zw_count: got aw %0d w %0d b %0d, expected %0d each",
                     aw_log.size(), w_log.size(), b_log, NW);
        end
        for (int i = 0; i < NW && i < aw_log.size() && i < w_log.size(); i++) begin
            vectors++;
            if (aw_log[i] !== ref_addr[i] || w_log[i] !== ref_data[i] || strb_log[i] !== 4'hF) begin
                miscompares++;
                $display("FAIL zw_beat%0d: got %h/%h/%h, expected %h/%h/f",
                         i, aw_log[i], w_log[i], strb_log[i], ref_addr[i], ref_data[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        int cyc;
        for (int k = 0; k < 4; k++) begin
            // k==0: W accepted two cycles ahead of AW; later rounds randomised
            if (k == 0) set_delays(2, 2, 0, 0, 0, 0);
            else        set_delays(0, 3, 0, 3, 0, 3);
            err_at = -1;
            slave_reset();
            clear_log();
            pulse_start();
            cyc = -1;
            for (int c = 1; c <= 300; c++) begin
                // a start pulse mid-sequence must be ignored
                start_i = (k != 0) && (c == 4);
                tick();
                if (done_o || error_o) begin
                    cyc = c;
                    break;
                end
            end
            start_i = 1'b0;
            vectors++;
            if (cyc < 0 || done_o !== 1'b1 || error_o !== 1'b0) begin
                miscompares++;
                $display("FAIL bp%0d_status: got cyc %0d done %b err %b, expected done", k, cyc, done_o, error_o);
            end
            vectors++;
            if (aw_log.size() != NW || w_log.size() != NW || b_log != NW || stab_err != 0) begin
                miscompares++;
                $display("FAIL bp%0d_count: got aw %0d w %0d b %0d unstable %0d, expected %0d %0d %0d 0",
                         k, aw_log.size(), w_log.size(), b_log, stab_err, NW, NW, NW);
            end
            for (int i = 0; i < NW && i < aw_log.size() && i < w_log.size(); i++) begin
                vectors++;
                if (aw_log[i] !== ref_addr[i] || w_log[i] !== ref_data[i]) begin
                    miscompares++;
                    $display("FAIL bp%0d_beat%0d: got %h/%h, expected %h/%h",
                             k, i, aw_log[i], w_log[i], ref_addr[i], ref_data[i]);
                end
            end
        end
    endtask

    task automatic test_slverr();
        int cyc;
        set_delays(0, 0, 0, 0, 0, 0);
        err_at = 2;
        slave_reset();
        clear_log();
        pulse_start();
        wait_end(200, cyc);
        vectors++;
        if ({error_o, done_o, busy_o, err_idx_o} !== {3'b100, 4'd2}) begin
            miscompares++;
            $display("FAIL slverr_status: got err/done/busy %b idx %0d, expected 100 idx 2",
                     {error_o, done_o, busy_o}, err_idx_o);
        end
        vectors++;
        if ({m_awvalid, m_wvalid, m_bready} !== 3'b000) begin
            miscompares++;
            $display("FAIL slverr_idle: got %b, expected 000", {m_awvalid, m_wvalid, m_bready});
        end
        vectors++;
        if (aw_log.size() != exp_writes(err_at) || w_log.size() != exp_writes(err_at)) begin
            miscompares++;
            $display("FAIL slverr_count: got aw %0d w %0d, expected %0d",
                     aw_log.size(), w_log.size(), exp_writes(err_at));
        end
        // rerun from index 0 with a clean slave
        err_at = -1;
        slave_reset();
        clear_log();
        pulse_start();
        vectors++;
        if ({error_o, busy_o, err_idx_o} !== {2'b01, 4'd0}) begin
            miscompares++;
            $display("FAIL rerun_clear: got err/busy %b idx %0d, expected 01 idx 0",
                     {error_o, busy_o}, err_idx_o);
        end
        wait_end(200, cyc);
        vectors++;
        if (done_o !== 1'b1 || error_o !== 1'b0 || aw_log.size() != NW) begin
            miscompares++;
            $display("FAIL rerun_done: got done %b err %b writes %0d, expected 1 0 %0d",
                     done_o, error_o, aw_log.size(), NW);
        end
        for (int i = 0; i < NW && i < aw_log.size(); i++) begin
            vectors++;
            if (aw_log[i] !== ref_addr[i]) begin
                miscompares++;
                $display("FAIL rerun_beat%0d: got %h, expected %h", i, aw_log[i], ref_addr[i]);
            end
        end
    endtask

    task automatic test_timeout();
        int t_aw, t_err;
        set_delays(0, 0, 0, 0, 0, 0);
        err_at  = -1;
        never_b = 1'b1;
        slave_reset();
        clear_log();
        pulse_start();
        t_aw = -1; t_err = -1;
        for (int c = 1; c <= 100; c++) begin
            tick();
            if (m_awvalid && t_aw < 0) t_aw = c;
            if (error_o) begin
                t_err = c;
                break;
            end
        end
        never_b = 1'b0;
        vectors++;
        if (t_aw < 0 || t_err < 0 || t_err - t_aw != TMO) begin
            miscompares++;
            $display("FAIL tmo_latency: got awvalid@%0d error@%0d, expected gap %0d", t_aw, t_err, TMO);
        end
        vectors++;
        if ({m_awvalid, m_wvalid, m_bready, busy_o, done_o, err_idx_o} !== {5'b00000, 4'd0}) begin
            miscompares++;
            $display("FAIL tmo_state: got v/v/br/busy/done %b idx %0d, expected 00000 idx 0",
                     {m_awvalid, m_wvalid, m_bready, busy_o, done_o}, err_idx_o);
        end
    endtask

    task automatic test_timeout_race();
        int cyc;
        // B arrives in the 16th cycle counted from the first awvalid cycle,
        // i.e. exactly on the timeout cycle, for every write
        set_delays(0, 0, 0, 0, TMO - 2, TMO - 2);
        err_at = -1;
        slave_reset();
        clear_log();
        pulse_start();
        wait_end(300, cyc);
        vectors++;
        if (done_o !== 1'b1 || error_o !== 1'b0 || b_log != NW) begin
            miscompares++;
            $display("FAIL race_status: got done %b err %b b %0d, expected 1 0 %0d",
                     done_o, error_o, b_log, NW);
        end
    endtask

    task automatic test_reset_mid();
        int  cyc;
        bit  hit;
        set_delays(0, 0, 0, 0, 0, 0);
        err_at = -1;
        slave_reset();
        clear_log();
        pulse_start();
        hit = 1'b0;
        for (int c = 1; c <= 50 && !hit; c++) begin
            tick();
            hit = (aw_log.size() == 2) && m_bready;
        end
        vectors++;
        if (!hit) begin
            miscompares++;
            $display("FAIL mid_reach: got no RESP on write 1, expected one");
        end
        rst = 1'b1;   // mid-cycle, away from any clock edge
        #1;
        vectors++;
        if ({m_awvalid, m_wvalid, m_bready, busy_o, done_o, error_o, err_idx_o} !== 10'b0) begin
            miscompares++;
            $display("FAIL mid_async: got %b, expected all zero",
                     {m_awvalid, m_wvalid, m_bready, busy_o, done_o, error_o, err_idx_o});
        end
        tick();
        slave_reset();
        clear_log();
        rst = 1'b0;
        wait_end(100, cyc);
        vectors++;
        if (cyc !== exp_done_cycle() || done_o !== 1'b1 || aw_log.size() != NW) begin
            miscompares++;
            $display("FAIL mid_restart: got cyc %0d done %b writes %0d, expected %0d 1 %0d",
                     cyc, done_o, aw_log.size(), exp_done_cycle(), NW);
        end
        vectors++;
        if (aw_log.size() == 0 || aw_log[0] !== ref_addr[0]) begin
            miscompares++;
            $display("FAIL mid_first: got first addr %h, expected %h",
                     (aw_log.size() != 0) ? aw_log[0] : 32'hx, ref_addr[0]);
        end
    endtask

    initial begin
        logic [NW*32-1:0] a_tab, d_tab;
        a_tab = TB_ADDR;
        d_tab = TB_DATA;
        for (int i = 0; i < NW; i++) begin
            ref_addr[i] = a_tab[i*32 +: 32];
            ref_data[i] = d_tab[i*32 +: 32];
        end
        rst = 1'b1;
        start_i = 1'b0;
        test_reset();
        test_zero_wait();
        test_backpressure();
        test_slverr();
        test_timeout();
        test_timeout_race();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
